regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single synchronous write port of the 32x32 register file between two writeback
//  sources: port 0 = ALU result, port 1 = memory load. Uses valid/ready per source and round-robin
//  (or fixed) priority, then drives RegWrite/WriteRegister/WriteData from an output register stage.
//  Provides forwarding hits for both read ports to cover the one-cycle write latency.
//  Sits between the execute/memory stages and regfile; regfile clock = this block's clock.
// PARAMETERS
//  FIXED_PRIO  0   0: round-robin between ports; 1: port 0 always wins
//  CNT_W       16  width of saturating conflict counter
// PORTS
//  clock          in   1      rising-edge clock (shared with regfile)
//  reset_n        in   1      synchronous, active-low reset
//  wb_en          in   1      global writeback enable; 0 => both ready low
//  wr0_valid      in   1      port 0 (ALU) request
//  wr0_addr       in   5      port 0 destination register
//  wr0_data       in   32     port 0 data
//  wr0_ready      out  1      port 0 accepted this cycle (combinational)
//  wr1_valid      in   1      port 1 (MEM) request
//  wr1_addr       in   5      port 1 destination register
//  wr1_data       in   32     port 1 data
//  wr1_ready      out  1      port 1 accepted this cycle (combinational)
//  RegWrite       out  1      regfile write enable (registered)
//  WriteRegister  out  5      regfile write address (registered)
//  WriteData      out  32     regfile write data (registered)
//  rd_addr1       in   5      regfile ReadRegister1, observed for forwarding
//  rd_addr2       in   5      regfile ReadRegister2, observed for forwarding
//  fwd_hit1       out  1      RegWrite & WriteRegister==rd_addr1 & rd_addr1!=0
//  fwd_hit2       out  1      same for rd_addr2; forwarded value is WriteData
//  conflict_cnt   out  CNT_W  cycles in which both ports valid while wb_en=1; saturates
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): RegWrite=0, WriteRegister=0, WriteData=0, rr_ptr=0,
//    conflict_cnt=0. Any accepted-but-not-yet-written request is discarded. ready=0 while reset_n=0.
//  - Grant (combinational, cycle N): wb_en=0 => no grant. One valid => that port granted.
//    Both valid => FIXED_PRIO=1: port 0; else port rr_ptr. At most one ready high per cycle.
//  - rr_ptr updates only on a conflict cycle: becomes the port NOT granted. Single-port grants
//    leave rr_ptr unchanged.
//  - Accept = valid & ready. Latency 1: accept in cycle N => RegWrite=1 with captured addr/data
//    throughout cycle N+1; regfile stores at edge ending N+1. No accept => RegWrite=0 in N+1,
//    WriteRegister/WriteData hold last values.
//  - Address 0: request is accepted (ready=1) but RegWrite stays 0 in N+1; address/data still
//    captured. rr_ptr/counter behave as for any other address.
//  - Non-granted valid port keeps its request; requester must hold addr/data stable until ready.
//  - Back-to-back accepts allowed every cycle (full throughput, no bubbles).
//  - Forwarding: fwd_hit* purely combinational from registered stage and rd_addr*; never hits
//    on register 0. Consumer muxes WriteData when hit.
//  - conflict_cnt: +1 at each edge where wr0_valid&wr1_valid&wb_en&reset_n; holds at 2^CNT_W-1.
//  - wb_en deassert mid-stream: staged write in flight still completes next cycle; no new accepts.
// TESTING
//  1. Port 0 only: wr0 addr=5 data=0xDEADBEEF -> ready0=1 cycle N; RegWrite=1, WriteRegister=5,
//     WriteData=0xDEADBEEF in N+1; RegWrite=0 in N+2.
//  2. Both valid 4 cycles, FIXED_PRIO=0, rr_ptr=0 -> grants 0,1,0,1; RegWrite every cycle;
//     conflict_cnt=4. With FIXED_PRIO=1 -> grants 0,0,0,0, port 1 stalled.
//  3. wr1 addr=0 data=0x1234 -> ready1=1, RegWrite=0 next cycle; fwd_hit1=0 with rd_addr1=0.
//  4. Write addr=7, rd_addr1=7 & rd_addr2=3 in N+1 -> fwd_hit1=1, fwd_hit2=0.
//  5. Accept in N, reset_n=0 at edge ending N -> RegWrite=0 in N+1, all outputs/counter zero.
//  6. CNT_W=2, both valid 6 cycles -> conflict_cnt 1,2,3,3,3,3; wb_en=0 -> both ready=0, no count.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register file.
// Two sources (port 0 = ALU, port 1 = memory load) share the single regfile write port.
// A grant is made combinationally in cycle N. The winner is captured into an output
// register stage that drives the regfile in cycle N+1. The registered stage is also
// compared with both read addresses so that consumers can forward WriteData during the
// one-cycle write latency.
module regfile_wb_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wb_en,
    input  logic             wr0_valid,
    input  logic [4:0]       wr0_addr,
    input  logic [31:0]      wr0_data,
    output logic             wr0_ready,
    input  logic             wr1_valid,
    input  logic [4:0]       wr1_addr,
    input  logic [31:0]      wr1_data,
    output logic             wr1_ready,
    output logic             RegWrite,
    output logic [4:0]       WriteRegister,
    output logic [31:0]      WriteData,
    input  logic [4:0]       rd_addr1,
    input  logic [4:0]       rd_addr2,
    output logic             fwd_hit1,
    output logic             fwd_hit2,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             req0;
    logic             req1;
    logic             conflict;
    logic             grant0;
    logic             grant1;
    logic             rr_ptr_q;
    logic             rr_ptr_d;
    logic             reg_write_q;
    logic             reg_write_d;
    logic [4:0]       wr_reg_q;
    logic [4:0]       wr_reg_d;
    logic [31:0]      wr_data_q;
    logic [31:0]      wr_data_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Grant selection: reset or a disabled writeback blocks both ports.
    always_comb begin
        req0     = reset_n & wb_en & wr0_valid;
        req1     = reset_n & wb_en & wr1_valid;
        conflict = req0 & req1;
        grant0   = 1'b0;
        grant1   = 1'b0;
        if (conflict) begin
            if (FIXED_PRIO || !rr_ptr_q) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = req0;
            grant1 = req1;
        end
    end

    assign wr0_ready = grant0;
    assign wr1_ready = grant1;

    // Next state for the round-robin pointer, conflict counter and write stage.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        reg_write_d = 1'b0;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;

        // Only a real contest moves the pointer; it then favours the loser.
        if (conflict) begin
            rr_ptr_d = grant0;
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Register 0 is accepted and captured but never written.
        if (grant0) begin
            reg_write_d = (wr0_addr != 5'd0);
            wr_reg_d    = wr0_addr;
            wr_data_d   = wr0_data;
        end else if (grant1) begin
            reg_write_d = (wr1_addr != 5'd0);
            wr_reg_d    = wr1_addr;
            wr_data_d   = wr1_data;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr_q    <= 1'b0;
            cnt_q       <= '0;
            reg_write_q <= 1'b0;
            wr_reg_q    <= 5'd0;
            wr_data_q   <= 32'd0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            reg_write_q <= reg_write_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign RegWrite      = reg_write_q;
    assign WriteRegister = wr_reg_q;
    assign WriteData     = wr_data_q;
    assign conflict_cnt  = cnt_q;

    // Forwarding hits come straight from the registered stage; register 0 never hits.
    assign fwd_hit1 = reg_write_q && (wr_reg_q == rd_addr1) && (rd_addr1 != 5'd0);
    assign fwd_hit2 = reg_write_q && (wr_reg_q == rd_addr2) && (rd_addr2 != 5'd0);

endmodule
